// File: rtl/ccx_pkg.sv
// ccx_pkg: shared widths and arbiter state encoding for the ccx_top external memory path.
package ccx_pkg;
    localparam int CCX_EMEM_AW = 39;
    localparam int CCX_EMEM_DW = 64;
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} ccx_emem_arb_state_t;
endpackage

// File: rtl/ccx_emem_arb_rr.sv
// ccx_emem_arb_rr: 2-way round-robin picker; on a tie the port not granted last wins.
module ccx_emem_arb_rr (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       gnt_idx_o,
    output logic       any_o
);
    assign gnt_idx_o = &req_i ? ~last_i : req_i[1];
    assign any_o     = |req_i;
endmodule

// File: rtl/ccx_emem_arbiter.sv
// ccx_emem_arbiter: shares the emem port between core (s0) and aux (s1), one transaction at a time.
// Optional busy-timeout with error response and drain: CCX_EMEM_ARB_TIMEOUT_EN.
module ccx_emem_arbiter
    import ccx_pkg::*;
#(
    parameter int AW = CCX_EMEM_AW,
    parameter int DW = CCX_EMEM_DW
`ifdef CCX_EMEM_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic            f_clk,
    input  logic            g_resetn,
    input  logic            s0_req,
    input  logic            s0_rtype,
    input  logic [AW-1:0]   s0_addr,
    input  logic            s0_wen,
    input  logic [DW/8-1:0] s0_strb,
    input  logic [DW-1:0]   s0_wdata,
    input  logic [1:0]      s0_prv,
    output logic            s0_gnt,
    output logic            s0_err,
    output logic [DW-1:0]   s0_rdata,
    input  logic            s1_req,
    input  logic            s1_rtype,
    input  logic [AW-1:0]   s1_addr,
    input  logic            s1_wen,
    input  logic [DW/8-1:0] s1_strb,
    input  logic [DW-1:0]   s1_wdata,
    input  logic [1:0]      s1_prv,
    output logic            s1_gnt,
    output logic            s1_err,
    output logic [DW-1:0]   s1_rdata,
    output logic            emem_req,
    output logic            emem_rtype,
    output logic [AW-1:0]   emem_addr,
    output logic            emem_wen,
    output logic [DW/8-1:0] emem_strb,
    output logic [DW-1:0]   emem_wdata,
    output logic [1:0]      emem_prv,
    input  logic            emem_gnt,
    input  logic            emem_err,
    input  logic [DW-1:0]   emem_rdata,
    output logic            arb_busy,
    output logic            arb_owner
);
    ccx_emem_arb_state_t state_q;
    logic            owner_q, last_q, win, any;
    logic            rtype_q, wen_q;
    logic [AW-1:0]   addr_q;
    logic [DW/8-1:0] strb_q;
    logic [DW-1:0]   wdata_q;
    logic [1:0]      prv_q;
    logic            busy, tmo, rsp_gnt, rsp_err;
    logic [DW-1:0]   rsp_rdata;
`ifdef CCX_EMEM_ARB_TIMEOUT_EN
    logic [31:0]     cnt_q;
`endif

    ccx_emem_arb_rr u_rr (
        .req_i    ({s1_req, s0_req}),
        .last_i   (last_q),
        .gnt_idx_o(win),
        .any_o    (any)
    );

    always_ff @(posedge f_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            rtype_q <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
            prv_q   <= '0;
`ifdef CCX_EMEM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (any) begin
                    state_q <= BUSY;
                    owner_q <= win;
                    last_q  <= win;
                    rtype_q <= win ? s1_rtype : s0_rtype;
                    addr_q  <= win ? s1_addr  : s0_addr;
                    wen_q   <= win ? s1_wen   : s0_wen;
                    strb_q  <= win ? s1_strb  : s0_strb;
                    wdata_q <= win ? s1_wdata : s0_wdata;
                    prv_q   <= win ? s1_prv   : s0_prv;
`ifdef CCX_EMEM_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
`ifdef CCX_EMEM_ARB_TIMEOUT_EN
                BUSY: if (emem_gnt) state_q <= IDLE;
                    else if (tmo) state_q <= DRAIN;
                    else cnt_q <= cnt_q + 32'd1;
`else
                BUSY: if (emem_gnt) state_q <= IDLE;
`endif
                // DRAIN: the late downstream response is swallowed
                default: if (emem_gnt) state_q <= IDLE;
            endcase
        end
    end

    assign busy = state_q == BUSY;
`ifdef CCX_EMEM_ARB_TIMEOUT_EN
    assign tmo = busy && !emem_gnt && cnt_q == 32'(TIMEOUT_CYCLES - 1);
`else
    assign tmo = 1'b0;
`endif
    assign rsp_gnt   = busy && (emem_gnt || tmo);
    assign rsp_err   = busy && (emem_err || tmo);
    assign rsp_rdata = (busy && !tmo) ? emem_rdata : '0;

    assign s0_gnt   = rsp_gnt && !owner_q;
    assign s0_err   = rsp_err && !owner_q;
    assign s0_rdata = owner_q ? '0 : rsp_rdata;
    assign s1_gnt   = rsp_gnt && owner_q;
    assign s1_err   = rsp_err && owner_q;
    assign s1_rdata = owner_q ? rsp_rdata : '0;

    assign emem_req   = state_q != IDLE;
    assign emem_rtype = rtype_q;
    assign emem_addr  = addr_q;
    assign emem_wen   = wen_q;
    assign emem_strb  = strb_q;
    assign emem_wdata = wdata_q;
    assign emem_prv   = prv_q;
    assign arb_busy   = emem_req;
    assign arb_owner  = owner_q;
endmodule
